ccff_readback_reader: RTL and testbench

- Reads back the fabric configuration chains at the tail end.
- Runs the configuration-chain shift on prog_clk and samples one bit per chain per shift, giving NUM_CHAINS-bit columns.
- Streams the columns out over a valid/ready interface and keeps a running CRC over the whole readback.
- With recirculation on, it feeds each tail bit back into its chain head so the configuration is intact after a full pass.

---
 rtl/ccff_readback_pkg.sv | 35 +++
 rtl/ccff_skid_fifo2.sv | 66 ++++++
 rtl/ccff_readback_reader.sv | 150 +++++++++++++++
 tb/tb_ccff_readback_reader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_readback_pkg.sv
// Shared types, constants and the column CRC helper for configuration-chain readback.
package ccff_readback_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDrain
  } state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // Widest column crc16_column() accepts; narrower columns are zero-extended.
  localparam int unsigned MaxChains = 64;

  // Fold the low n bits of col into crc, bit 0 (chain 0) first, MSB-first CRC-16-CCITT.
  function automatic logic [15:0] crc16_column(input logic [15:0]          crc,
                                               input logic [MaxChains-1:0] col,
                                               input int unsigned          n);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int unsigned i = 0; i < MaxChains; i++) begin
      if (i < n) begin
        fb = c[15] ^ col[i];
        c  = {c[14:0], 1'b0};
        if (fb) begin
          c = c ^ CRC16_POLY;
        end
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/ccff_skid_fifo2.sv
// Two-entry FIFO; entry 0 is always the head. Push to a full FIFO is dropped
// unless a pop happens in the same cycle.
module ccff_skid_fifo2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem0_q, mem0_d;
  logic [Width-1:0] mem1_q, mem1_d;
  logic [1:0]       count_q, count_d;

  // Next-state for storage and occupancy.
  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else if (push_i && pop_i) begin
      if (count_q == 2'd2) begin
        mem0_d = mem1_q;
        mem1_d = data_i;
      end else begin
        // Empty-with-pop cannot pop anything, so it degenerates to a push.
        mem0_d  = data_i;
        count_d = 2'd1;
      end
    end else if (push_i) begin
      if (count_q == 2'd0) begin
        mem0_d  = data_i;
        count_d = 2'd1;
      end else if (count_q == 2'd1) begin
        mem1_d  = data_i;
        count_d = 2'd2;
      end
    end else if (pop_i && (count_q != 2'd0)) begin
      mem0_d  = mem1_q;
      count_d = count_q - 2'd1;
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  assign data_o  = mem0_q;
  assign count_o = count_q;

endmodule

// File: rtl/ccff_readback_reader.sv
// Shifts the configuration chains out at the tail, streams each column over
// valid/ready through a 2-entry skid buffer and keeps a running CRC-16.
module ccff_readback_reader #(
  parameter int unsigned NUM_CHAINS = 12,
  parameter int unsigned CHAIN_LEN  = 4096,
  parameter int unsigned CNT_W      = 13
) (
  input  logic                  prog_clk,
  input  logic                  pReset_n,
  input  logic                  start,
  input  logic                  recirc,
  input  logic                  abort,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic [NUM_CHAINS-1:0] ccff_head,
  output logic                  cfg_shift_en,
  output logic [NUM_CHAINS-1:0] col_data,
  output logic                  col_valid,
  input  logic                  col_ready,
  output logic                  col_last,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [15:0]           crc
);

  import ccff_readback_pkg::*;

  localparam int unsigned DataW = NUM_CHAINS + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             recirc_q, recirc_d;
  logic             aborted_q, aborted_d;
  logic             abort_q, abort_d;   // set for the cycle right after an abort
  logic [15:0]      crc_q, crc_d;
  logic [15:0]      crc_hold_q, crc_hold_d;

  logic             shift_en;
  logic             fifo_push, fifo_pop, fifo_flush;
  logic [DataW-1:0] fifo_din, fifo_dout;
  logic [1:0]       fifo_count;
  logic             fifo_empty;
  logic             done_int;

  ccff_skid_fifo2 #(
    .Width (DataW)
  ) u_fifo (
    .clk_i   (prog_clk),
    .rst_ni  (pReset_n),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .data_i  (fifo_din),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .count_o (fifo_count)
  );

  // Shift gating and handshake; only registered state feeds shift_en.
  always_comb begin
    fifo_empty = (fifo_count == 2'd0);
    shift_en   = (state_q == StShift) && (cnt_q < CNT_W'(CHAIN_LEN)) && (fifo_count != 2'd2);
    done_int   = (state_q == StDrain) && fifo_empty && !abort_q;
    fifo_din   = {(cnt_q == CNT_W'(CHAIN_LEN - 1)), ccff_tail};
    fifo_pop   = !fifo_empty && col_ready;
  end

  // Next-state: run control, counter, CRC and frozen CRC output.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    recirc_d   = recirc_q;
    aborted_d  = aborted_q;
    abort_d    = 1'b0;
    crc_d      = crc_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StShift;
          recirc_d  = recirc;
          cnt_d     = '0;
          aborted_d = 1'b0;
          crc_d     = CRC16_INIT;
        end
      end
      StShift: begin
        if (abort) begin
          state_d    = StDrain;
          fifo_flush = 1'b1;
          aborted_d  = 1'b1;
          abort_d    = 1'b1;
        end else if (shift_en) begin
          fifo_push = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
          crc_d     = crc16_column(crc_q, MaxChains'(ccff_tail), NUM_CHAINS);
          if (cnt_d == CNT_W'(CHAIN_LEN)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (done_int) begin
          state_d = StIdle;
        end else if (abort) begin
          fifo_flush = 1'b1;
          aborted_d  = 1'b1;
          abort_d    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    crc_hold_d = done_int ? crc_q : crc_hold_q;
  end

  // State registers.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      recirc_q   <= 1'b0;
      aborted_q  <= 1'b0;
      abort_q    <= 1'b0;
      crc_q      <= CRC16_INIT;
      crc_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      recirc_q   <= recirc_d;
      aborted_q  <= aborted_d;
      abort_q    <= abort_d;
      crc_q      <= crc_d;
      crc_hold_q <= crc_hold_d;
    end
  end

  // Outputs; col_last is masked so a stale head entry never shows through.
  always_comb begin
    ccff_head    = (recirc_q && shift_en) ? ccff_tail : '0;
    cfg_shift_en = shift_en;
    col_valid    = !fifo_empty;
    col_data     = fifo_dout[NUM_CHAINS-1:0];
    col_last     = fifo_dout[NUM_CHAINS] && !fifo_empty;
    busy         = (state_q != StIdle);
    done         = done_int;
    aborted      = aborted_q;
    crc          = done_int ? crc_q : crc_hold_q;
  end

endmodule

// File: tb/tb_ccff_readback_reader.sv
// Self-checking bench: behavioural chain fabric, column scoreboard and a
// bit-stream CRC reference built from the chain contents at run start.
module tb_ccff_readback_reader;

  localparam int unsigned NC = 12;
  localparam int unsigned CL = 8;
  localparam int unsigned CW = 4;

  logic          prog_clk = 1'b0;
  logic          pReset_n = 1'b1;
  logic          start, recirc, abort, col_ready;
  logic [NC-1:0] ccff_tail, ccff_head, col_data;
  logic          cfg_shift_en, col_valid, col_last, busy, done, aborted;
  logic [15:0]   crc;

  always #5 prog_clk = ~prog_clk;

  ccff_readback_reader #(
    .NUM_CHAINS (NC),
    .CHAIN_LEN  (CL),
    .CNT_W      (CW)
  ) u_dut (
    .prog_clk     (prog_clk),
    .pReset_n     (pReset_n),
    .start        (start),
    .recirc       (recirc),
    .abort        (abort),
    .ccff_tail    (ccff_tail),
    .ccff_head    (ccff_head),
    .cfg_shift_en (cfg_shift_en),
    .col_data     (col_data),
    .col_valid    (col_valid),
    .col_ready    (col_ready),
    .col_last     (col_last),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .crc          (crc)
  );

  // Fabric model: bit CL-1 is the tail, the head enters at bit 0.
  logic [CL-1:0] chain    [NC];
  logic [CL-1:0] load_val [NC];
  logic          load_en = 1'b0;

  always @(posedge prog_clk) begin
    for (int i = 0; i < NC; i++) begin
      if (load_en) chain[i] <= load_val[i];
      else if (cfg_shift_en) chain[i] <= {chain[i][CL-2:0], ccff_head[i]};
    end
  end

  always_comb begin
    for (int i = 0; i < NC; i++) ccff_tail[i] = chain[i][CL-1];
  end

  int            n_pass = 0;
  int            n_total = 0;
  logic [CL-1:0] snap [NC];
  int            npop, nshift, cyc, last_pop_cyc;
  bit            cur_rc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Column k of a readback: the k-th bit from the tail end of every chain.
  function automatic logic [NC-1:0] col_of(input int k);
    logic [NC-1:0] c;
    c = '0;
    if (k >= 0 && k < CL) begin
      for (int i = 0; i < NC; i++) c[i] = snap[i][CL-1-k];
    end
    return c;
  endfunction

  // Reference CRC over the serial stream of the first n columns.
  function automatic logic [15:0] ref_crc(input int n);
    logic          bits[$];
    logic [NC-1:0] col;
    logic [15:0]   c;
    logic          fb;
    for (int k = 0; k < n; k++) begin
      col = col_of(k);
      for (int i = 0; i < NC; i++) bits.push_back(col[i]);
    end
    c = 16'hFFFF;
    foreach (bits[j]) begin
      fb = c[15] ^ bits[j];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic load_chains(input bit rnd);
    for (int i = 0; i < NC; i++) load_val[i] = rnd ? CL'($urandom) : CL'(8'hA5 ^ i);
    load_en = 1'b1;
    @(negedge prog_clk);
    load_en = 1'b0;
  endtask

  task automatic take_snap();
    for (int i = 0; i < NC; i++) snap[i] = chain[i];
    npop = 0;
    nshift = 0;
    last_pop_cyc = -1;
  endtask

  // Observe the cycle before the edge, then advance one clock (negedge to negedge).
  task automatic cycle();
    int outst;
    outst = nshift - npop;
    if (outst >= 2) chk("stall_when_full", 32'(cfg_shift_en), 32'(0));
    if (col_valid && col_ready && !abort) begin
      if (npop < CL) begin
        chk("col_data", 32'(col_data), 32'(col_of(npop)));
        chk("col_last", 32'(col_last), 32'(npop == CL - 1));
      end else begin
        chk("extra_column", 32'(npop), 32'(CL - 1));
      end
      npop++;
      last_pop_cyc = cyc;
    end
    if (cfg_shift_en && !abort) nshift++;
    if (busy && !cur_rc) chk("head_zero", 32'(ccff_head), 32'(0));
    @(posedge prog_clk);
    @(negedge prog_clk);
    cyc++;
  endtask

  // One complete readback from the current chain contents.
  task automatic run(input bit rc, input int mode, input bit poke);
    bit got;
    got = 1'b0;
    take_snap();
    cur_rc = rc;
    start = 1'b1;
    recirc = rc;
    col_ready = 1'b1;
    cycle();
    start = 1'b0;
    recirc = 1'b0;
    chk("start_busy", 32'(busy), 32'(1));
    chk("start_clears_aborted", 32'(aborted), 32'(0));
    for (int t = 0; t < 400 && !got; t++) begin
      if (done) begin
        got = 1'b1;
      end else begin
        case (mode)
          0: col_ready = 1'b1;
          1: col_ready = (t % 3 == 0);
          default: col_ready = 1'($urandom_range(0, 1));
        endcase
        start = poke && (t == 2);
        cycle();
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(got), 32'(1));
    chk("columns_popped", 32'(npop), 32'(CL));
    chk("shifts", 32'(nshift), 32'(CL));
    chk("done_latency", 32'(cyc), 32'(last_pop_cyc + 1));
    chk("crc_full", 32'(crc), 32'(ref_crc(CL)));
    chk("not_aborted", 32'(aborted), 32'(0));
    cycle();
    chk("done_pulse", 32'(done), 32'(0));
    chk("idle_after", 32'(busy), 32'(0));
    chk("crc_held", 32'(crc), 32'(ref_crc(CL)));
    for (int i = 0; i < NC; i++) chk("chain_after", 32'(chain[i]), rc ? 32'(snap[i]) : 32'(0));
  endtask

  initial begin
    start = 1'b0;
    recirc = 1'b0;
    abort = 1'b0;
    col_ready = 1'b0;
    cyc = 0;
    cur_rc = 1'b1;
    npop = 0;
    nshift = 0;
    #1 pReset_n = 1'b0;
    @(negedge prog_clk);
    chk("rst_shift_en", 32'(cfg_shift_en), 32'(0));
    chk("rst_valid", 32'(col_valid), 32'(0));
    chk("rst_last", 32'(col_last), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_aborted", 32'(aborted), 32'(0));
    chk("rst_crc", 32'(crc), 32'(0));
    chk("rst_head", 32'(ccff_head), 32'(0));
    pReset_n = 1'b1;
    load_chains(1'b0);

    // Recirculating and destructive readbacks, ready always high.
    run(1'b1, 0, 1'b0);
    run(1'b0, 0, 1'b0);

    // Backpressure: ready one cycle in three.
    load_chains(1'b0);
    run(1'b1, 1, 1'b0);

    // Abort after three shifts with one column pending.
    load_chains(1'b0);
    take_snap();
    cur_rc = 1'b1;
    start = 1'b1;
    recirc = 1'b1;
    col_ready = 1'b1;
    cycle();
    start = 1'b0;
    for (int t = 0; t < 20 && nshift < 3; t++) cycle();
    chk("abort_reach_3", 32'(nshift), 32'(3));
    chk("abort_pending", 32'(col_valid), 32'(1));
    abort = 1'b1;
    col_ready = 1'b0;
    cycle();
    abort = 1'b0;
    col_ready = 1'b1;
    chk("abort_flush", 32'(col_valid), 32'(0));
    chk("abort_no_shift", 32'(cfg_shift_en), 32'(0));
    chk("abort_done_wait", 32'(done), 32'(0));
    chk("abort_flag", 32'(aborted), 32'(1));
    chk("abort_busy", 32'(busy), 32'(1));
    cycle();
    chk("abort_done", 32'(done), 32'(1));
    chk("abort_crc", 32'(crc), 32'(ref_crc(3)));
    // Start during the done cycle is ignored.
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("start_at_done_ignored", 32'(busy), 32'(0));
    chk("aborted_kept", 32'(aborted), 32'(1));
    chk("abort_crc_held", 32'(crc), 32'(ref_crc(3)));
    // Accepted one cycle after done; a start pulse mid-SHIFT must not disturb it.
    run(1'b1, 0, 1'b1);

    // Asynchronous reset mid-SHIFT.
    load_chains(1'b0);
    take_snap();
    cur_rc = 1'b1;
    start = 1'b1;
    recirc = 1'b1;
    col_ready = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    chk("pre_reset_shifting", 32'(cfg_shift_en), 32'(1));
    #2 pReset_n = 1'b0;
    #1;
    chk("mid_rst_shift_en", 32'(cfg_shift_en), 32'(0));
    chk("mid_rst_valid", 32'(col_valid), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_done", 32'(done), 32'(0));
    chk("mid_rst_crc", 32'(crc), 32'(0));
    @(negedge prog_clk);
    pReset_n = 1'b1;
    load_chains(1'b0);
    run(1'b1, 0, 1'b0);

    // Random chain contents with random backpressure.
    load_chains(1'b1);
    run(1'b1, 2, 1'b0);
    run(1'b0, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
